// File: rtl/kws_pkg.sv
// Shared definitions for the keyword-spotting back end: default widths,
// the argmax scan FSM encoding and an index-width helper.
package kws_pkg;

    localparam int ACTIV_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Vector input handshake plus classification result bundle for argmax_classifier.
interface argmax_classifier_if #(
    parameter int NUM_CLASSES = 128,
    parameter int ACTIV_BITS  = 8,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
);
    logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in;
    logic                              data_valid;
    logic                              data_ready;
    logic [IDX_W-1:0]                  class_idx;
    logic [ACTIV_BITS-1:0]             class_prob;
    logic                              class_valid;
    logic                              class_detected;
    logic [15:0]                       frames_dropped;

    modport master (
        output data_in, data_valid,
        input  data_ready, class_idx, class_prob, class_valid,
               class_detected, frames_dropped
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, class_idx, class_prob, class_valid,
               class_detected, frames_dropped
    );
endinterface

// File: rtl/detect_debounce.sv
// Confidence threshold and consecutive-same-winner hold counter; produces
// the debounced detection flag once per frame strobe.
module detect_debounce
    import kws_pkg::*;
#(
    parameter int                    IDX_W       = 7,
    parameter int                    ACTIV_BITS  = ACTIV_BITS_DEF,
    parameter logic [ACTIV_BITS-1:0] THRESHOLD   = 128,
    parameter int                    HOLD_FRAMES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_strobe,
    input  logic [IDX_W-1:0]      idx,
    input  logic [ACTIV_BITS-1:0] prob,
    output logic                  class_detected
);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_FRAMES);

    logic [IDX_W-1:0] prev_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic             confident;

    // Hold counter saturates at HOLD_MAX so a steady winner keeps detection asserted.
    always_comb begin
        confident = (prob >= THRESHOLD);
        hold_next = '0;
        if (confident) begin
            if (idx == prev_idx)
                hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
            else
                hold_next = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_idx       <= '0;
            hold_cnt       <= '0;
            class_detected <= 1'b0;
        end else if (frame_strobe) begin
            prev_idx       <= idx;
            hold_cnt       <= hold_next;
            class_detected <= (hold_next == HOLD_MAX);
        end
    end
endmodule

// File: rtl/argmax_classifier.sv
// Latches a softmax probability vector, scans it one class per clock for the
// maximum (ties to lowest index) and reports the debounced keyword decision.
module argmax_classifier
    import kws_pkg::*;
#(
    parameter int                    NUM_CLASSES = 128,
    parameter int                    ACTIV_BITS  = ACTIV_BITS_DEF,
    parameter logic [ACTIV_BITS-1:0] THRESHOLD   = 8'd128,
    parameter int                    HOLD_FRAMES = 3
) (
    input  logic               clk,
    input  logic               rst,
    argmax_classifier_if.slave bus
);
    localparam int               IDX_W    = idx_width(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                state, state_next;
    logic [ACTIV_BITS-1:0] vec [NUM_CLASSES];
    logic [ACTIV_BITS-1:0] best_val;
    logic [IDX_W-1:0]      best_idx;
    logic [IDX_W-1:0]      scan_idx;
    logic [ACTIV_BITS-1:0] cur_val;
    logic [IDX_W-1:0]      class_idx_r;
    logic [ACTIV_BITS-1:0] class_prob_r;
    logic                  class_valid_r;
    logic [15:0]           frames_dropped_r;
    logic                  accept;

    assign accept  = (state == IDLE) && bus.data_valid;
    assign cur_val = vec[scan_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.data_valid) state_next = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Element 0 seeds the best registers at capture, so the scan starts at index 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) vec[i] <= '0;
            best_val         <= '0;
            best_idx         <= '0;
            scan_idx         <= '0;
            class_idx_r      <= '0;
            class_prob_r     <= '0;
            class_valid_r    <= 1'b0;
            frames_dropped_r <= '0;
        end else begin
            class_valid_r <= 1'b0;
            if (accept) begin
                for (int i = 0; i < NUM_CLASSES; i++)
                    vec[i] <= bus.data_in[i*ACTIV_BITS +: ACTIV_BITS];
                best_val <= bus.data_in[ACTIV_BITS-1:0];
                best_idx <= '0;
                scan_idx <= IDX_W'(1);
            end
            if (state == SCAN) begin
                if (cur_val > best_val) begin
                    best_val <= cur_val;
                    best_idx <= scan_idx;
                end
                scan_idx <= scan_idx + IDX_W'(1);
            end
            if (state == DONE) begin
                class_idx_r   <= best_idx;
                class_prob_r  <= best_val;
                class_valid_r <= 1'b1;
            end
            if (bus.data_valid && (state != IDLE) && (frames_dropped_r != 16'hFFFF))
                frames_dropped_r <= frames_dropped_r + 16'd1;
        end
    end

    detect_debounce #(
        .IDX_W       (IDX_W),
        .ACTIV_BITS  (ACTIV_BITS),
        .THRESHOLD   (THRESHOLD),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .frame_strobe   (state == DONE),
        .idx            (best_idx),
        .prob           (best_val),
        .class_detected (bus.class_detected)
    );

    assign bus.data_ready     = (state == IDLE);
    assign bus.class_idx      = class_idx_r;
    assign bus.class_prob     = class_prob_r;
    assign bus.class_valid    = class_valid_r;
    assign bus.frames_dropped = frames_dropped_r;
endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier with 4 classes, threshold 128, hold of 2 frames.
module tb_argmax_classifier;
    localparam int NC = 4;
    localparam int AB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] prob;
        logic       det;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    argmax_classifier_if #(.NUM_CLASSES(NC), .ACTIV_BITS(AB)) bus ();

    argmax_classifier #(
        .NUM_CLASSES (NC),
        .ACTIV_BITS  (AB),
        .THRESHOLD   (8'd128),
        .HOLD_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every class_valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.class_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("class_idx", int'(bus.class_idx), int'(e.idx));
                check_output("class_prob", int'(bus.class_prob), int'(e.prob));
                check_output("class_detected", int'(bus.class_detected), int'(e.det));
                check_output("latency_cycle", cyc, e.cyc);
                check_output("ready_in_valid_cycle", int'(bus.data_ready), 1);
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] v0, input logic [7:0] v1,
                                  input logic [7:0] v2, input logic [7:0] v3,
                                  input logic [1:0] ei, input logic [7:0] ep,
                                  input logic ed, input bit expect_out);
        exp_t e;
        int   n = 0;
        while (!bus.data_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.data_ready) begin
            check_output("ready_timeout", 0, 1);
            return;
        end
        bus.data_in    = {v3, v2, v1, v0};
        bus.data_valid = 1'b1;
        if (expect_out) begin
            e.idx  = ei;
            e.prob = ep;
            e.det  = ed;
            e.cyc  = cyc + 1 + NC;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_data_ready", int'(bus.data_ready), 1);
        check_output("rst_class_valid", int'(bus.class_valid), 0);
        check_output("rst_class_idx", int'(bus.class_idx), 0);
        check_output("rst_class_prob", int'(bus.class_prob), 0);
        check_output("rst_detected", int'(bus.class_detected), 0);
        check_output("rst_dropped", int'(bus.frames_dropped), 0);
        rst = 1'b0;
        @(negedge clk);

        // Abandon a frame mid-scan: no pulse may follow the release.
        apply_stimulus(8'd1, 8'd250, 8'd3, 8'd4, 2'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("midscan_ready", int'(bus.data_ready), 1);
        check_output("midscan_valid", int'(bus.class_valid), 0);
        check_output("midscan_prob", int'(bus.class_prob), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        apply_stimulus(8'd10, 8'd200, 8'd50, 8'd30, 2'd1, 8'd200, 1'b0, 1'b1);
        apply_stimulus(8'd10, 8'd200, 8'd50, 8'd30, 2'd1, 8'd200, 1'b1, 1'b1);
        apply_stimulus(8'd10, 8'd20, 8'd150, 8'd5, 2'd2, 8'd150, 1'b0, 1'b1);
        apply_stimulus(8'd90, 8'd90, 8'd90, 8'd90, 2'd0, 8'd90, 1'b0, 1'b1);
        wait_drain();

        // Three vectors offered during SCAN must be dropped without disturbing the scan.
        apply_stimulus(8'd5, 8'd60, 8'd70, 8'd65, 2'd2, 8'd70, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.data_in    = '1;
            bus.data_valid = 1'b1;
            @(negedge clk);
        end
        bus.data_valid = 1'b0;
        check_output("dropped_during_scan", int'(bus.frames_dropped), 3);
        wait_drain();
        check_output("dropped_after", int'(bus.frames_dropped), 3);

        apply_stimulus(8'd0, 8'd0, 8'd0, 8'd128, 2'd3, 8'd128, 1'b0, 1'b1);
        apply_stimulus(8'd0, 8'd0, 8'd0, 8'd128, 2'd3, 8'd128, 1'b1, 1'b1);
        apply_stimulus(8'd0, 8'd0, 8'd0, 8'd128, 2'd3, 8'd128, 1'b1, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);
        check_output("detected_held", int'(bus.class_detected), 1);
        check_output("idle_ready", int'(bus.data_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Downstream consumer of the softmax stage in the keyword-spotting pipeline.
- Latches one softmax probability vector and scans it serially, one class per clock, to find the winning class and its probability.
- Applies a confidence threshold plus a consecutive-frame debounce, then emits the final keyword decision to the system interface.

Parameters:
- NUM_CLASSES, 128: number of probabilities in the input vector (≥2); matches softmax OUTPUT_SIZE.
- ACTIV_BITS, 8: width of each unsigned probability.
- THRESHOLD, 8'd128: minimum winning probability for a frame to count as confident.
- HOLD_FRAMES, 3: consecutive confident frames with the same winner required to assert detection (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  NUM_CLASSES*ACTIV_BITS  probability vector; class i at [i*ACTIV_BITS +: ACTIV_BITS].
- data_valid  in  1  vector valid; accepted only when data_ready=1.
- data_ready  out  1  block can accept a vector.
- class_idx  out  $clog2(NUM_CLASSES)  winning class index.
- class_prob  out  ACTIV_BITS  winning probability.
- class_valid  out  1  one-cycle pulse; class_idx and class_prob are new.
- class_detected  out  1  debounced detection flag; updates together with class_valid.
- frames_dropped  out  16  saturating count of data_valid pulses seen while data_ready=0.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0 except data_ready=1. State IDLE. Vector register, best registers, scan index and hold counter all 0. Reset mid-scan abandons the frame with no class_valid.
- FSM states: IDLE, SCAN, DONE.
- data_ready is 1 exactly when the state is IDLE, including the cycle in which class_valid is high.
- IDLE: on an edge with data_valid=1:
  - capture data_in into the vector register;
  - best_val = element 0, best_idx = 0, scan_idx = 1;
  - go to SCAN.
- SCAN: each cycle, compare element[scan_idx] with best_val.
  - Replace the best only if strictly greater, so ties go to the lowest index.
  - Increment scan_idx. After comparing index NUM_CLASSES-1, go to DONE.
- DONE: on one edge:
  - register class_idx = best_idx and class_prob = best_val;
  - pulse class_valid;
  - update the debounce logic;
  - return to IDLE.
- Latency: capture edge T produces class_valid high in the cycle after edge T+NUM_CLASSES. Throughput is one frame per NUM_CLASSES+1 cycles.
- data_valid while not in IDLE: the vector is ignored and frames_dropped increments, saturating at 16'hFFFF. A dropped frame never corrupts the scan in progress.
- Debounce, evaluated in DONE:
  - A frame is confident if best_val ≥ THRESHOLD (unsigned).
  - If confident and best_idx equals the previous frame's winner: hold_cnt = min(hold_cnt+1, HOLD_FRAMES).
  - If confident but the winner differs: hold_cnt = 1.
  - If not confident: hold_cnt = 0.
  - The previous winner always updates to best_idx.
  - class_detected = (hold_cnt_next == HOLD_FRAMES). It is held between class_valid pulses.
  - With HOLD_FRAMES=1, any single confident frame detects.
- All-zero vector: class_idx=0, class_prob=0, not confident.
- Arithmetic: all comparisons unsigned, ACTIV_BITS wide. hold_cnt is $clog2(HOLD_FRAMES+1) bits and never wraps.

Decomposition:
- Shared package (kws_pkg): ACTIV_BITS default, FSM state encoding constants (IDLE/SCAN/DONE), index-width helper function.
- One natural sub-module: detect_debounce.
  - Inputs: frame strobe, idx, prob.
  - Contains: threshold compare, previous-winner register, hold counter.
  - Output: class_detected.
- Scan and FSM stay in argmax_classifier.

Test Plan (bench uses NUM_CLASSES=4, THRESHOLD=128, HOLD_FRAMES=2):
- Reset asserted mid-scan → outputs immediately 0, data_ready=1; no class_valid pulse after release.
- Vector {10,200,50,30} (class0..3) accepted at edge T → class_valid in the cycle after edge T+4; class_idx=1, class_prob=200, class_detected=0.
- Same vector sent on the next data_ready → class_detected=1. A third frame {10,20,150,5} → idx=2, detected=0 (hold resets to 1).
- Tie vector {90,90,90,90} → class_idx=0, class_prob=90, not confident; hold_cnt=0, detected=0.
- data_valid pulsed on 3 cycles during SCAN → frames_dropped=3, result equals the originally captured frame. Back-to-back acceptance in the class_valid cycle works.
- Boundary vector {0,0,0,128} → idx=3, prob=128 counts as confident (≥). Two such frames → detected=1.
